alu_rsv_station: RTL and testbench

- Reservation station placed directly upstream of the integer ALU in the superscalar execute cluster.
- Accepts decoded ALU micro-ops from dispatch and holds them until both operands are valid.
- Captures missing operands by snooping two common-data-bus (CDB) write-back ports.
- Issues one ready micro-op per cycle to the ALU: src1, src2, 5-bit func, destination tag.

---
 rtl/alu_rsv_station_if.sv | 47 ++++
 rtl/alu_rsv_station.sv | 129 ++++++++++++
 tb/tb_alu_rsv_station.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_rsv_station_if.sv
// Dispatch, CDB snoop, issue and status signals of the ALU reservation station.
// The station connects through the slave modport.
interface alu_rsv_station_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 6
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic              flush;
    logic              disp_valid;
    logic              disp_ready;
    logic [4:0]        disp_func;
    logic [31:0]       disp_src1_data;
    logic              disp_src1_rdy;
    logic [TAG_W-1:0]  disp_src1_tag;
    logic [31:0]       disp_src2_data;
    logic              disp_src2_rdy;
    logic [TAG_W-1:0]  disp_src2_tag;
    logic [TAG_W-1:0]  disp_dst_tag;
    logic              cdb0_valid;
    logic [TAG_W-1:0]  cdb0_tag;
    logic [31:0]       cdb0_data;
    logic              cdb1_valid;
    logic [TAG_W-1:0]  cdb1_tag;
    logic [31:0]       cdb1_data;
    logic              iss_valid;
    logic              iss_ready;
    logic [4:0]        iss_func;
    logic [31:0]       iss_src1;
    logic [31:0]       iss_src2;
    logic [TAG_W-1:0]  iss_dst_tag;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output flush, disp_valid, disp_func, disp_src1_data, disp_src1_rdy, disp_src1_tag,
               disp_src2_data, disp_src2_rdy, disp_src2_tag, disp_dst_tag,
               cdb0_valid, cdb0_tag, cdb0_data, cdb1_valid, cdb1_tag, cdb1_data, iss_ready,
        input  disp_ready, iss_valid, iss_func, iss_src1, iss_src2, iss_dst_tag, occupancy
    );

    modport slave (
        input  flush, disp_valid, disp_func, disp_src1_data, disp_src1_rdy, disp_src1_tag,
               disp_src2_data, disp_src2_rdy, disp_src2_tag, disp_dst_tag,
               cdb0_valid, cdb0_tag, cdb0_data, cdb1_valid, cdb1_tag, cdb1_data, iss_ready,
        output disp_ready, iss_valid, iss_func, iss_src1, iss_src2, iss_dst_tag, occupancy
    );
endinterface

// File: rtl/alu_rsv_station.sv
// Reservation station ahead of the integer ALU: holds micro-ops until both
// operands are captured from dispatch or the two CDB ports, then issues in index order.
module alu_rsv_station #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_rsv_station_if.slave  rs
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic              valid_q   [DEPTH];
    logic [4:0]        func_q    [DEPTH];
    logic [TAG_W-1:0]  dst_q     [DEPTH];
    logic              s1_rdy_q  [DEPTH];
    logic [TAG_W-1:0]  s1_tag_q  [DEPTH];
    logic [31:0]       s1_data_q [DEPTH];
    logic              s2_rdy_q  [DEPTH];
    logic [TAG_W-1:0]  s2_tag_q  [DEPTH];
    logic [31:0]       s2_data_q [DEPTH];
    logic [OCC_W-1:0]  occ_q;

    logic              free_found, sel_found;
    logic [IDX_W-1:0]  free_idx, sel_idx;
    logic              disp_ready, disp_fire, iss_fire;
    logic [32:0]       w1 [DEPTH];
    logic [32:0]       w2 [DEPTH];
    logic [32:0]       dw1, dw2;

    // Returns {hit, data}; cdb0 has priority when both ports carry the tag.
    function automatic logic [32:0] snoop(
        input logic [TAG_W-1:0] tag,
        input logic v0, input logic [TAG_W-1:0] t0, input logic [31:0] d0,
        input logic v1, input logic [TAG_W-1:0] t1, input logic [31:0] d1
    );
        if (v0 && (t0 == tag)) return {1'b1, d0};
        if (v1 && (t1 == tag)) return {1'b1, d1};
        return {1'b0, 32'h0};
    endfunction

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!free_found && !valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (!sel_found && valid_q[i] && s1_rdy_q[i] && s2_rdy_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            w1[i] = snoop(s1_tag_q[i], rs.cdb0_valid, rs.cdb0_tag, rs.cdb0_data,
                          rs.cdb1_valid, rs.cdb1_tag, rs.cdb1_data);
            w2[i] = snoop(s2_tag_q[i], rs.cdb0_valid, rs.cdb0_tag, rs.cdb0_data,
                          rs.cdb1_valid, rs.cdb1_tag, rs.cdb1_data);
        end
        dw1 = snoop(rs.disp_src1_tag, rs.cdb0_valid, rs.cdb0_tag, rs.cdb0_data,
                    rs.cdb1_valid, rs.cdb1_tag, rs.cdb1_data);
        dw2 = snoop(rs.disp_src2_tag, rs.cdb0_valid, rs.cdb0_tag, rs.cdb0_data,
                    rs.cdb1_valid, rs.cdb1_tag, rs.cdb1_data);
    end

    // Registered occupancy only: a slot freed by this cycle's issue is not reusable yet.
    assign disp_ready = (occ_q != OCC_W'(DEPTH));
    assign disp_fire  = rs.disp_valid && disp_ready && free_found;
    assign iss_fire   = sel_found && rs.iss_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                valid_q[i]   <= 1'b0;
                func_q[i]    <= '0;
                dst_q[i]     <= '0;
                s1_rdy_q[i]  <= 1'b0;
                s1_tag_q[i]  <= '0;
                s1_data_q[i] <= '0;
                s2_rdy_q[i]  <= 1'b0;
                s2_tag_q[i]  <= '0;
                s2_data_q[i] <= '0;
            end
            occ_q <= '0;
        end else if (rs.flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
            occ_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (valid_q[i]) begin
                    if (!s1_rdy_q[i] && w1[i][32]) begin
                        s1_rdy_q[i]  <= 1'b1;
                        s1_data_q[i] <= w1[i][31:0];
                    end
                    if (!s2_rdy_q[i] && w2[i][32]) begin
                        s2_rdy_q[i]  <= 1'b1;
                        s2_data_q[i] <= w2[i][31:0];
                    end
                    if (iss_fire && (sel_idx == IDX_W'(i))) valid_q[i] <= 1'b0;
                end else if (disp_fire && (free_idx == IDX_W'(i))) begin
                    valid_q[i]   <= 1'b1;
                    func_q[i]    <= rs.disp_func;
                    dst_q[i]     <= rs.disp_dst_tag;
                    s1_tag_q[i]  <= rs.disp_src1_tag;
                    s1_rdy_q[i]  <= rs.disp_src1_rdy || dw1[32];
                    s1_data_q[i] <= rs.disp_src1_rdy ? rs.disp_src1_data : dw1[31:0];
                    s2_tag_q[i]  <= rs.disp_src2_tag;
                    s2_rdy_q[i]  <= rs.disp_src2_rdy || dw2[32];
                    s2_data_q[i] <= rs.disp_src2_rdy ? rs.disp_src2_data : dw2[31:0];
                end
            end
            case ({disp_fire, iss_fire})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign rs.disp_ready  = disp_ready;
    assign rs.occupancy   = occ_q;
    assign rs.iss_valid   = sel_found;
    assign rs.iss_func    = sel_found ? func_q[sel_idx]    : '0;
    assign rs.iss_src1    = sel_found ? s1_data_q[sel_idx] : '0;
    assign rs.iss_src2    = sel_found ? s2_data_q[sel_idx] : '0;
    assign rs.iss_dst_tag = sel_found ? dst_q[sel_idx]     : '0;
endmodule

// File: tb/tb_alu_rsv_station.sv
// Directed-vector bench for alu_rsv_station; inputs change and outputs are
// sampled on the falling clock edge.
module tb_alu_rsv_station;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    alu_rsv_station_if #(.DEPTH(4), .TAG_W(6)) bus ();

    alu_rsv_station #(.DEPTH(4), .TAG_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rs    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.flush      = 1'b0;
        bus.disp_valid = 1'b0;
        bus.cdb0_valid = 1'b0;
        bus.cdb1_valid = 1'b0;
    endtask

    task automatic disp(input logic [4:0] f,
                        input logic [31:0] d1, input logic r1, input logic [5:0] t1,
                        input logic [31:0] d2, input logic r2, input logic [5:0] t2,
                        input logic [5:0] dst);
        bus.disp_valid     = 1'b1;
        bus.disp_func      = f;
        bus.disp_src1_data = d1;
        bus.disp_src1_rdy  = r1;
        bus.disp_src1_tag  = t1;
        bus.disp_src2_data = d2;
        bus.disp_src2_rdy  = r2;
        bus.disp_src2_tag  = t2;
        bus.disp_dst_tag   = dst;
    endtask

    task automatic cdb(input int port, input logic [5:0] tag, input logic [31:0] data);
        if (port == 0) begin
            bus.cdb0_valid = 1'b1;
            bus.cdb0_tag   = tag;
            bus.cdb0_data  = data;
        end else begin
            bus.cdb1_valid = 1'b1;
            bus.cdb1_tag   = tag;
            bus.cdb1_data  = data;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        bus.iss_ready = 1'b0;
        bus.disp_func = '0;
        bus.disp_src1_data = '0; bus.disp_src1_rdy = 1'b0; bus.disp_src1_tag = '0;
        bus.disp_src2_data = '0; bus.disp_src2_rdy = 1'b0; bus.disp_src2_tag = '0;
        bus.disp_dst_tag = '0;
        bus.cdb0_tag = '0; bus.cdb0_data = '0;
        bus.cdb1_tag = '0; bus.cdb1_data = '0;

        repeat (2) step();
        check_eq("rst_occ",   32'(bus.occupancy), 32'd0);
        check_eq("rst_ivld",  32'(bus.iss_valid), 32'd0);
        check_eq("rst_drdy",  32'(bus.disp_ready), 32'd1);
        check_eq("rst_src1",  bus.iss_src1, 32'd0);
        rst_n = 1'b1;
        step();

        // 1: both operands ready
        disp(5'b00011, 32'h10, 1'b1, 6'd0, 32'h20, 1'b1, 6'd0, 6'd7);
        bus.iss_ready = 1'b1;
        step(); idle();
        check_eq("t1_ivld", 32'(bus.iss_valid), 32'd1);
        check_eq("t1_func", 32'(bus.iss_func), 32'h3);
        check_eq("t1_src1", bus.iss_src1, 32'h10);
        check_eq("t1_src2", bus.iss_src2, 32'h20);
        check_eq("t1_dst",  32'(bus.iss_dst_tag), 32'd7);
        step();
        check_eq("t1_occ0", 32'(bus.occupancy), 32'd0);
        check_eq("t1_ivld0", 32'(bus.iss_valid), 32'd0);
        check_eq("t1_src1z", bus.iss_src1, 32'd0);

        // 2: wakeup via cdb1, tag mismatch in MSB only, then cdb0 priority
        disp(5'h11, 32'h5, 1'b1, 6'd0, 32'h0, 1'b0, 6'd12, 6'd9);
        step(); idle();
        check_eq("t2_wait_ivld", 32'(bus.iss_valid), 32'd0);
        check_eq("t2_wait_occ",  32'(bus.occupancy), 32'd1);
        step();
        cdb(1, 6'd44, 32'h0000_0BAD);
        step(); idle();
        check_eq("t2_nomatch", 32'(bus.iss_valid), 32'd0);
        cdb(1, 6'd12, 32'hDEAD_0001);
        check_eq("t2_nobypass", 32'(bus.iss_valid), 32'd0);
        step(); idle();
        check_eq("t2_ivld", 32'(bus.iss_valid), 32'd1);
        check_eq("t2_src2", bus.iss_src2, 32'hDEAD_0001);
        check_eq("t2_src1", bus.iss_src1, 32'h5);
        check_eq("t2_func", 32'(bus.iss_func), 32'h11);
        check_eq("t2_dst",  32'(bus.iss_dst_tag), 32'd9);
        step();
        check_eq("t2_occ0", 32'(bus.occupancy), 32'd0);
        disp(5'h2, 32'h6, 1'b1, 6'd0, 32'h0, 1'b0, 6'd12, 6'd10);
        step(); idle();
        cdb(0, 6'd12, 32'h1);
        cdb(1, 6'd12, 32'h2);
        step(); idle();
        check_eq("t2_prio_src2", bus.iss_src2, 32'h1);
        check_eq("t2_prio_dst",  32'(bus.iss_dst_tag), 32'd10);
        step();

        // 3: dispatch collides with matching cdb0 broadcast
        disp(5'h4, 32'h0, 1'b0, 6'd3, 32'h77, 1'b1, 6'd0, 6'd11);
        cdb(0, 6'd3, 32'hABCD);
        step(); idle();
        check_eq("t3_ivld", 32'(bus.iss_valid), 32'd1);
        check_eq("t3_src1", bus.iss_src1, 32'hABCD);
        check_eq("t3_src2", bus.iss_src2, 32'h77);
        step();
        check_eq("t3_occ0", 32'(bus.occupancy), 32'd0);

        // 4: fill, overflow attempt, in-order drain
        bus.iss_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            disp(5'h5, 32'(k), 1'b1, 6'd0, 32'(k * 2), 1'b1, 6'd0, 6'(k));
            step();
        end
        idle();
        check_eq("t4_occ4", 32'(bus.occupancy), 32'd4);
        check_eq("t4_drdy0", 32'(bus.disp_ready), 32'd0);
        check_eq("t4_dst1", 32'(bus.iss_dst_tag), 32'd1);
        disp(5'h5, 32'h55, 1'b1, 6'd0, 32'h55, 1'b1, 6'd0, 6'd5);
        step(); idle();
        check_eq("t4_full_occ", 32'(bus.occupancy), 32'd4);
        check_eq("t4_hold_dst", 32'(bus.iss_dst_tag), 32'd1);
        check_eq("t4_hold_vld", 32'(bus.iss_valid), 32'd1);
        bus.iss_ready = 1'b1;
        step();
        check_eq("t4_dst2", 32'(bus.iss_dst_tag), 32'd2);
        check_eq("t4_drdy1", 32'(bus.disp_ready), 32'd1);
        check_eq("t4_occ3", 32'(bus.occupancy), 32'd3);
        step();
        check_eq("t4_dst3", 32'(bus.iss_dst_tag), 32'd3);
        step();
        check_eq("t4_dst4", 32'(bus.iss_dst_tag), 32'd4);
        check_eq("t4_src2_4", bus.iss_src2, 32'd8);
        step();
        check_eq("t4_occ0", 32'(bus.occupancy), 32'd0);
        check_eq("t4_ivld0", 32'(bus.iss_valid), 32'd0);

        // 5: flush with coincident dispatch and issue
        bus.iss_ready = 1'b0;
        disp(5'h6, 32'h0, 1'b0, 6'd20, 32'h1, 1'b1, 6'd0, 6'd21);
        step();
        disp(5'h6, 32'h2, 1'b1, 6'd0, 32'h3, 1'b1, 6'd0, 6'd22);
        step();
        disp(5'h6, 32'h4, 1'b1, 6'd0, 32'h5, 1'b1, 6'd0, 6'd23);
        step(); idle();
        check_eq("t5_occ3", 32'(bus.occupancy), 32'd3);
        check_eq("t5_dst22", 32'(bus.iss_dst_tag), 32'd22);
        bus.flush = 1'b1;
        bus.iss_ready = 1'b1;
        disp(5'h7, 32'h6, 1'b1, 6'd0, 32'h7, 1'b1, 6'd0, 6'd24);
        step(); idle();
        check_eq("t5_occ0", 32'(bus.occupancy), 32'd0);
        check_eq("t5_ivld0", 32'(bus.iss_valid), 32'd0);
        check_eq("t5_drdy1", 32'(bus.disp_ready), 32'd1);
        cdb(0, 6'd20, 32'h99);
        step(); idle();
        check_eq("t5_stale_ivld", 32'(bus.iss_valid), 32'd0);
        check_eq("t5_stale_occ", 32'(bus.occupancy), 32'd0);

        // 6: asynchronous reset between edges
        bus.iss_ready = 1'b0;
        disp(5'h8, 32'h1, 1'b1, 6'd0, 32'h2, 1'b1, 6'd0, 6'd30);
        step();
        disp(5'h8, 32'h3, 1'b1, 6'd0, 32'h4, 1'b1, 6'd0, 6'd31);
        step(); idle();
        check_eq("t6_occ2", 32'(bus.occupancy), 32'd2);
        check_eq("t6_ivld1", 32'(bus.iss_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_ivld0", 32'(bus.iss_valid), 32'd0);
        check_eq("t6_occ0", 32'(bus.occupancy), 32'd0);
        check_eq("t6_drdy1", 32'(bus.disp_ready), 32'd1);
        check_eq("t6_dst0", 32'(bus.iss_dst_tag), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check_eq("t6_post_occ", 32'(bus.occupancy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
